// File: rtl/lcd_serial_responder.sv
// lcd_serial_responder: display-side end of the LCD serial register interface.
// Latency: serial lines pass a 2-flop sync plus an edge stage (3 clocks) before decode.
// Backpressure: none; the controller's serial clock paces every bit.
module lcd_serial_responder #(
  parameter logic [7:0]  HW_CONFIG_VALUE = 8'h20,
  parameter logic [23:0] HW_ID_VALUE     = 24'h000000,
  parameter int          SCRATCH_DEPTH   = 16
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_serialClock,
  input  logic       i_serialEnable,
  input  logic       i_serialData,
  output logic       o_serialData,
  output logic       o_writeStrobe,
  output logic [6:0] o_writeAddress,
  output logic [7:0] o_writeData,
  output logic       o_frameError,
  output logic       o_busy
);

  localparam int IW = (SCRATCH_DEPTH > 1) ? $clog2(SCRATCH_DEPTH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_READ, S_WRITE, S_DONE} state_t;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [7:0]  shift_q;
  logic [7:0]  shift_d;
  logic [7:0]  out_q;
  logic [6:0]  addr_q;
  logic        armed_q;
  logic [7:0]  rd_val;
  logic [7:0]  scratch_q [SCRATCH_DEPTH];

  logic sclk_s1_q, sclk_s2_q, sclk_prev_q;
  logic en_s1_q, en_s2_q;
  logic dat_s1_q, dat_s2_q;
  logic sclk_rise, sclk_fall;
  logic addr_in_scratch;
  logic wr_in_scratch;

  // Synchronizers and serial-clock history; left unreset so that a reset
  // with enable held high does not look like a fresh enable rise afterwards.
  always_ff @(posedge i_clock) begin
    sclk_s1_q   <= i_serialClock;
    sclk_s2_q   <= sclk_s1_q;
    sclk_prev_q <= sclk_s2_q;
    en_s1_q     <= i_serialEnable;
    en_s2_q     <= en_s1_q;
    dat_s1_q    <= i_serialData;
    dat_s2_q    <= dat_s1_q;
  end

  assign sclk_rise = sclk_s2_q & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s2_q & sclk_prev_q;

  // Byte as it will look after shifting in the current synchronized bit.
  assign shift_d         = {shift_q[6:0], dat_s2_q};
  assign addr_in_scratch = ({25'd0, shift_d[6:0]} < SCRATCH_DEPTH);
  assign wr_in_scratch   = ({25'd0, addr_q} < SCRATCH_DEPTH);

  // Read map lookup for the address byte completing this cycle.
  always_comb begin
    rd_val = 8'h00;
    if (addr_in_scratch) begin
      rd_val = scratch_q[shift_d[IW-1:0]];
    end else begin
      case (shift_d[6:0])
        7'h78:   rd_val = HW_CONFIG_VALUE;
        7'h79:   rd_val = HW_ID_VALUE[7:0];
        7'h7A:   rd_val = HW_ID_VALUE[15:8];
        7'h7B:   rd_val = HW_ID_VALUE[23:16];
        default: rd_val = 8'h00;
      endcase
    end
  end

  // Frame decoder FSM with registered outputs and the scratch register file.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      shift_q        <= '0;
      out_q          <= '0;
      addr_q         <= '0;
      armed_q        <= 1'b0;
      o_serialData   <= 1'b0;
      o_writeStrobe  <= 1'b0;
      o_writeAddress <= '0;
      o_writeData    <= '0;
      o_frameError   <= 1'b0;
      o_busy         <= 1'b0;
      for (int i = 0; i < SCRATCH_DEPTH; i++) scratch_q[i] <= '0;
    end else begin
      o_writeStrobe <= 1'b0;
      if ((state_q == S_ADDR || state_q == S_READ || state_q == S_WRITE) && !en_s2_q) begin
        // Enable dropped mid-frame: abort, takes priority over any edge.
        state_q      <= S_IDLE;
        o_frameError <= 1'b1;
        o_serialData <= 1'b0;
        o_busy       <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            o_serialData <= 1'b0;
            // A new frame needs enable seen low first, then high.
            if (!en_s2_q) begin
              armed_q <= 1'b1;
            end else if (armed_q) begin
              armed_q <= 1'b0;
              state_q <= S_ADDR;
              cnt_q   <= '0;
              shift_q <= '0;
              o_busy  <= 1'b1;
            end
          end
          S_ADDR: begin
            if (sclk_rise) begin
              shift_q <= shift_d;
              cnt_q   <= cnt_q + 5'd1;
              if (cnt_q == 5'd7) begin
                addr_q <= shift_d[6:0];
                if (shift_d[7]) begin
                  out_q   <= rd_val;
                  state_q <= S_READ;
                end else begin
                  state_q <= S_WRITE;
                end
              end
            end
          end
          S_READ: begin
            if (sclk_fall) begin
              o_serialData <= out_q[7];
              out_q        <= {out_q[6:0], 1'b0};
            end
            if (sclk_rise) begin
              cnt_q <= cnt_q + 5'd1;
              if (cnt_q == 5'd15) begin
                state_q      <= S_DONE;
                o_serialData <= 1'b0;
              end
            end
          end
          S_WRITE: begin
            if (sclk_rise) begin
              shift_q <= shift_d;
              cnt_q   <= cnt_q + 5'd1;
              if (cnt_q == 5'd15) begin
                state_q <= S_DONE;
                if (wr_in_scratch) begin
                  scratch_q[addr_q[IW-1:0]] <= shift_d;
                  o_writeStrobe  <= 1'b1;
                  o_writeAddress <= addr_q;
                  o_writeData    <= shift_d;
                end
              end
            end
          end
          S_DONE: begin
            o_serialData <= 1'b0;
            if (!en_s2_q) begin
              state_q <= S_IDLE;
              o_busy  <= 1'b0;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lcd_serial_responder.sv
// tb_lcd_serial_responder: directed frames against the serial responder.
// Serial clock runs at 1/16 of the system clock (8 cycles per phase).
// Read data is sampled by the bench just before each serial rising edge.
module tb_lcd_serial_responder;

  logic       i_clock = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_serialClock = 1'b0;
  logic       i_serialEnable = 1'b0;
  logic       i_serialData = 1'b0;
  logic       o_serialData;
  logic       o_writeStrobe;
  logic [6:0] o_writeAddress;
  logic [7:0] o_writeData;
  logic       o_frameError;
  logic       o_busy;

  int pass_cnt = 0;
  int total_cnt = 0;
  int strobe_cycles = 0;

  lcd_serial_responder #(
    .HW_CONFIG_VALUE(8'h20),
    .HW_ID_VALUE    (24'hC1B2A3),
    .SCRATCH_DEPTH  (16)
  ) dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_serialClock (i_serialClock),
    .i_serialEnable(i_serialEnable),
    .i_serialData  (i_serialData),
    .o_serialData  (o_serialData),
    .o_writeStrobe (o_writeStrobe),
    .o_writeAddress(o_writeAddress),
    .o_writeData   (o_writeData),
    .o_frameError  (o_frameError),
    .o_busy        (o_busy)
  );

  always #5 i_clock = ~i_clock;

  // Count every system cycle the strobe is high; a single write adds exactly 1.
  always @(negedge i_clock) if (o_writeStrobe === 1'b1) strobe_cycles++;

  // Drive nbits of a frame; rdat collects o_serialData before rising edges 9..16.
  task automatic frame(input logic rnw, input logic [6:0] addr, input logic [7:0] wdat,
                       input int nbits, output logic [7:0] rdat, output logic busy_mid);
    logic [15:0] w;
    w = {rnw, addr, wdat};
    rdat = 8'h00;
    @(negedge i_clock);
    i_serialEnable = 1'b1;
    repeat (8) @(negedge i_clock);
    for (int b = 0; b < nbits; b++) begin
      i_serialData = w[15-b];
      repeat (8) @(negedge i_clock);
      if (b >= 8) rdat = {rdat[6:0], o_serialData};
      i_serialClock = 1'b1;
      repeat (8) @(negedge i_clock);
      i_serialClock = 1'b0;
    end
    repeat (8) @(negedge i_clock);
    busy_mid = o_busy;
    i_serialEnable = 1'b0;
    i_serialData = 1'b0;
    repeat (8) @(negedge i_clock);
  endtask

  task automatic test_reset;
    i_reset = 1'b1;
    repeat (5) @(negedge i_clock);
    i_reset = 1'b0;
    @(negedge i_clock);
    total_cnt++;
    if (o_serialData !== 1'b0) $display("FAIL reset_sdo got %b want 0", o_serialData); else pass_cnt++;
    total_cnt++;
    if (o_writeStrobe !== 1'b0) $display("FAIL reset_strobe got %b want 0", o_writeStrobe); else pass_cnt++;
    total_cnt++;
    if (o_writeAddress !== 7'h00) $display("FAIL reset_waddr got %h want 00", o_writeAddress); else pass_cnt++;
    total_cnt++;
    if (o_writeData !== 8'h00) $display("FAIL reset_wdata got %h want 00", o_writeData); else pass_cnt++;
    total_cnt++;
    if (o_frameError !== 1'b0) $display("FAIL reset_ferr got %b want 0", o_frameError); else pass_cnt++;
    total_cnt++;
    if (o_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", o_busy); else pass_cnt++;
  endtask

  task automatic test_read_config;
    logic [7:0] r;
    logic bm;
    int s0;
    s0 = strobe_cycles;
    frame(1'b1, 7'h78, 8'hFF, 16, r, bm);
    total_cnt++;
    if (r !== 8'h20) $display("FAIL rd_cfg got %h want 20", r); else pass_cnt++;
    total_cnt++;
    if (bm !== 1'b1) $display("FAIL rd_cfg_busy_mid got %b want 1", bm); else pass_cnt++;
    total_cnt++;
    if (o_busy !== 1'b0) $display("FAIL rd_cfg_busy_end got %b want 0", o_busy); else pass_cnt++;
    total_cnt++;
    if (strobe_cycles != s0) $display("FAIL rd_cfg_strobe got %0d want %0d", strobe_cycles, s0); else pass_cnt++;
    total_cnt++;
    if (o_serialData !== 1'b0) $display("FAIL rd_cfg_sdo_idle got %b want 0", o_serialData); else pass_cnt++;
  endtask

  task automatic test_read_id;
    logic [7:0] r;
    logic bm;
    logic [7:0] exp_id [3];
    exp_id[0] = 8'hA3; exp_id[1] = 8'hB2; exp_id[2] = 8'hC1;
    for (int k = 0; k < 3; k++) begin
      frame(1'b1, 7'h79 + 7'(k), 8'h00, 16, r, bm);
      total_cnt++;
      if (r !== exp_id[k]) $display("FAIL rd_id%0d got %h want %h", k, r, exp_id[k]); else pass_cnt++;
    end
  endtask

  task automatic test_write;
    logic [7:0] r;
    logic bm;
    int s0;
    s0 = strobe_cycles;
    frame(1'b0, 7'h05, 8'hA5, 16, r, bm);
    total_cnt++;
    if (strobe_cycles != s0 + 1) $display("FAIL wr_strobe got %0d want %0d", strobe_cycles - s0, 1); else pass_cnt++;
    total_cnt++;
    if (o_writeAddress !== 7'h05) $display("FAIL wr_addr got %h want 05", o_writeAddress); else pass_cnt++;
    total_cnt++;
    if (o_writeData !== 8'hA5) $display("FAIL wr_data got %h want a5", o_writeData); else pass_cnt++;
    frame(1'b1, 7'h05, 8'h00, 16, r, bm);
    total_cnt++;
    if (r !== 8'hA5) $display("FAIL wr_readback got %h want a5", r); else pass_cnt++;
  endtask

  task automatic test_ignored_write;
    logic [7:0] r;
    logic bm;
    int s0;
    s0 = strobe_cycles;
    frame(1'b0, 7'h78, 8'h55, 16, r, bm);
    total_cnt++;
    if (strobe_cycles != s0) $display("FAIL ign_strobe got %0d want 0", strobe_cycles - s0); else pass_cnt++;
    total_cnt++;
    if (o_writeAddress !== 7'h05) $display("FAIL ign_addr got %h want 05", o_writeAddress); else pass_cnt++;
    total_cnt++;
    if (o_writeData !== 8'hA5) $display("FAIL ign_data got %h want a5", o_writeData); else pass_cnt++;
    frame(1'b1, 7'h78, 8'h00, 16, r, bm);
    total_cnt++;
    if (r !== 8'h20) $display("FAIL ign_cfg got %h want 20", r); else pass_cnt++;
    frame(1'b1, 7'h40, 8'h00, 16, r, bm);
    total_cnt++;
    if (r !== 8'h00) $display("FAIL rd_unmapped got %h want 00", r); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic [7:0] r;
    logic bm;
    int s0;
    frame(1'b0, 7'h0F, 8'h81, 16, r, bm);
    frame(1'b1, 7'h0F, 8'h00, 16, r, bm);
    total_cnt++;
    if (r !== 8'h81) $display("FAIL b2b_top_scratch got %h want 81", r); else pass_cnt++;
    s0 = strobe_cycles;
    frame(1'b0, 7'h10, 8'h77, 16, r, bm);
    total_cnt++;
    if (strobe_cycles != s0) $display("FAIL b2b_depth_strobe got %0d want 0", strobe_cycles - s0); else pass_cnt++;
    frame(1'b1, 7'h10, 8'h00, 16, r, bm);
    total_cnt++;
    if (r !== 8'h00) $display("FAIL b2b_depth_read got %h want 00", r); else pass_cnt++;
  endtask

  task automatic test_abort;
    logic [7:0] r;
    logic bm;
    int s0;
    frame(1'b0, 7'h03, 8'h3C, 16, r, bm);
    total_cnt++;
    if (o_frameError !== 1'b0) $display("FAIL abort_pre_ferr got %b want 0", o_frameError); else pass_cnt++;
    s0 = strobe_cycles;
    frame(1'b0, 7'h03, 8'h99, 10, r, bm);
    total_cnt++;
    if (o_frameError !== 1'b1) $display("FAIL abort_ferr got %b want 1", o_frameError); else pass_cnt++;
    total_cnt++;
    if (strobe_cycles != s0) $display("FAIL abort_strobe got %0d want 0", strobe_cycles - s0); else pass_cnt++;
    total_cnt++;
    if (o_busy !== 1'b0) $display("FAIL abort_busy got %b want 0", o_busy); else pass_cnt++;
    frame(1'b1, 7'h03, 8'h00, 16, r, bm);
    total_cnt++;
    if (r !== 8'h3C) $display("FAIL abort_readback got %h want 3c", r); else pass_cnt++;
    total_cnt++;
    if (o_frameError !== 1'b1) $display("FAIL abort_sticky got %b want 1", o_frameError); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    logic [7:0] r;
    logic bm;
    logic [15:0] w;
    int s0;
    w = {1'b1, 7'h78, 8'h00};
    @(negedge i_clock);
    i_serialEnable = 1'b1;
    repeat (8) @(negedge i_clock);
    for (int b = 0; b < 4; b++) begin
      i_serialData = w[15-b];
      repeat (8) @(negedge i_clock);
      i_serialClock = 1'b1;
      repeat (8) @(negedge i_clock);
      i_serialClock = 1'b0;
    end
    total_cnt++;
    if (o_busy !== 1'b1) $display("FAIL rstmid_busy_before got %b want 1", o_busy); else pass_cnt++;
    i_reset = 1'b1;
    @(negedge i_clock);
    i_reset = 1'b0;
    total_cnt++;
    if (o_serialData !== 1'b0) $display("FAIL rstmid_sdo got %b want 0", o_serialData); else pass_cnt++;
    total_cnt++;
    if (o_busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", o_busy); else pass_cnt++;
    total_cnt++;
    if (o_frameError !== 1'b0) $display("FAIL rstmid_ferr got %b want 0", o_frameError); else pass_cnt++;
    total_cnt++;
    if (o_writeAddress !== 7'h00) $display("FAIL rstmid_waddr got %h want 00", o_writeAddress); else pass_cnt++;
    // Remaining clocks with enable still high must not start decoding.
    s0 = strobe_cycles;
    for (int b = 4; b < 16; b++) begin
      i_serialData = 1'b1;
      repeat (8) @(negedge i_clock);
      i_serialClock = 1'b1;
      repeat (8) @(negedge i_clock);
      i_serialClock = 1'b0;
    end
    total_cnt++;
    if (o_busy !== 1'b0) $display("FAIL rstmid_wait_busy got %b want 0", o_busy); else pass_cnt++;
    i_serialEnable = 1'b0;
    i_serialData = 1'b0;
    repeat (8) @(negedge i_clock);
    frame(1'b1, 7'h05, 8'h00, 16, r, bm);
    total_cnt++;
    if (r !== 8'h00) $display("FAIL rstmid_scratch got %h want 00", r); else pass_cnt++;
    total_cnt++;
    if (bm !== 1'b1) $display("FAIL rstmid_new_frame_busy got %b want 1", bm); else pass_cnt++;
    total_cnt++;
    if (strobe_cycles != s0) $display("FAIL rstmid_strobe got %0d want 0", strobe_cycles - s0); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_read_config();
    test_read_id();
    test_write();
    test_ignored_write();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
